acc_fifo_arbiter: RTL

- Shares one ACC FIFO (4-entry, 32-bit, Push/Pop/Full/Empty) among NumLanes MAC lanes and sequences its drain towards the write-back stage.
- Round-robin push arbitration, valid/ready pop side, flush state machine, local occupancy counter.
- Sits between the MAC lane accumulators and the FIFO instance; owns every Push and Pop of that FIFO.

---
 rtl/acc_fifo_arbiter_pkg.sv | 24 ++
 rtl/acc_fifo_arbiter_if.sv | 46 ++++
 rtl/acc_fifo_arbiter_rr_arbiter.sv | 41 ++++
 rtl/acc_fifo_arbiter.sv | 120 ++++++++++++
 4 files changed

// File: rtl/acc_fifo_arbiter_pkg.sv
// ============================================================================
// Module : acc_pkg
// Brief  : Shared constants and FSM encoding for the ACC FIFO arbiter slice.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package acc_pkg;

  localparam int ACC_DATA_W     = 32;
  localparam int ACC_FIFO_DEPTH = 4;
  localparam int ACC_NUM_LANES  = 4;
  localparam int ACC_LANE_W     = $clog2(ACC_NUM_LANES);
  localparam int ACC_LEVEL_W    = $clog2(ACC_FIFO_DEPTH + 1);

  typedef logic [1:0] acc_state_t;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/acc_fifo_arbiter_if.sv
// ============================================================================
// Module : acc_fifo_arbiter_if
// Brief  : Lane, flush, FIFO and write-back signals of the ACC FIFO arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface acc_fifo_arbiter_if #(
  parameter int DATA_WIDTH  = acc_pkg::ACC_DATA_W,
  parameter int NUM_LANES   = acc_pkg::ACC_NUM_LANES,
  parameter int LEVEL_WIDTH = acc_pkg::ACC_LEVEL_W
);

  logic [NUM_LANES-1:0]            lane_req;
  logic [NUM_LANES*DATA_WIDTH-1:0] lane_data;
  logic [NUM_LANES-1:0]            lane_ack;
  logic                            flush;
  logic                            flush_done;
  logic                            fifo_push;
  logic [DATA_WIDTH-1:0]           fifo_din;
  logic                            fifo_pop;
  logic                            fifo_full;
  logic                            fifo_empty;
  logic [DATA_WIDTH-1:0]           fifo_dout;
  logic                            out_valid;
  logic [DATA_WIDTH-1:0]           out_data;
  logic                            out_ready;
  logic [LEVEL_WIDTH-1:0]          level;
  logic                            err_sync;

  // The arbiter is the slave; lanes, FIFO and write-back together form the master.
  modport slave (
    input  lane_req, lane_data, flush, fifo_full, fifo_empty, fifo_dout, out_ready,
    output lane_ack, flush_done, fifo_push, fifo_din, fifo_pop, out_valid, out_data,
           level, err_sync
  );

  modport master (
    output lane_req, lane_data, flush, fifo_full, fifo_empty, fifo_dout, out_ready,
    input  lane_ack, flush_done, fifo_push, fifo_din, fifo_pop, out_valid, out_data,
           level, err_sync
  );

endinterface

`default_nettype wire

// File: rtl/acc_fifo_arbiter_rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin picker: first request at or after i_ptr.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NUM_LANES  = 4,
  parameter int LANE_WIDTH = 2
) (
  input  logic [NUM_LANES-1:0]  i_req,
  input  logic [LANE_WIDTH-1:0] i_ptr,
  output logic [NUM_LANES-1:0]  o_grant,
  output logic [LANE_WIDTH-1:0] o_idx,
  output logic                  o_valid
);

  int                    w_sum;
  logic [LANE_WIDTH-1:0] w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_sum   = 0;
    w_j     = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      w_sum = int'(i_ptr) + k;
      w_j   = LANE_WIDTH'(w_sum % NUM_LANES);
      if (!o_valid && i_req[w_j]) begin
        o_valid      = 1'b1;
        o_grant[w_j] = 1'b1;
        o_idx        = w_j;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/acc_fifo_arbiter.sv
// ============================================================================
// Module : acc_fifo_arbiter
// Brief  : Owns push/pop of the shared ACC FIFO: lane arbitration, drain, flush.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module acc_fifo_arbiter
  import acc_pkg::*;
#(
  parameter int DATA_WIDTH  = ACC_DATA_W,
  parameter int NUM_LANES   = ACC_NUM_LANES,
  parameter int LANE_WIDTH  = ACC_LANE_W,
  parameter int BUFFER_SIZE = ACC_FIFO_DEPTH,
  parameter int LEVEL_WIDTH = ACC_LEVEL_W
) (
  input logic               clk,
  input logic               aclr,
  acc_fifo_arbiter_if.slave bus
);

  acc_state_t             r_state;
  logic [LANE_WIDTH-1:0]  r_ptr;
  logic [LEVEL_WIDTH-1:0] r_level;
  logic                   r_err;

  logic                   w_lvl_full;
  logic                   w_lvl_empty;
  logic                   w_push_en;
  logic [NUM_LANES-1:0]   w_req;
  logic [NUM_LANES-1:0]   w_grant;
  logic [LANE_WIDTH-1:0]  w_idx;
  logic                   w_push;
  logic                   w_valid;
  logic                   w_pop;
  logic [DATA_WIDTH-1:0]  w_din;

  assign w_lvl_full  = (r_level == LEVEL_WIDTH'(BUFFER_SIZE));
  assign w_lvl_empty = (r_level == '0);

  // Push uses the pre-pop full flag, so a same-cycle pop never opens a slot.
  assign w_push_en = ~aclr & (r_state == ST_RUN) & ~bus.fifo_full & ~w_lvl_full;
  assign w_req     = bus.lane_req & {NUM_LANES{w_push_en}};

  rr_arbiter #(
    .NUM_LANES  (NUM_LANES),
    .LANE_WIDTH (LANE_WIDTH)
  ) u_rr_arbiter (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_push)
  );

  always_comb begin
    w_din = '0;
    if (w_push) begin
      w_din = bus.lane_data[int'(w_idx)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign w_valid = ~bus.fifo_empty & ~aclr;
  assign w_pop   = w_valid & bus.out_ready & ~w_lvl_empty;

  assign bus.lane_ack   = w_grant;
  assign bus.fifo_push  = w_push;
  assign bus.fifo_din   = w_din;
  assign bus.fifo_pop   = w_pop;
  assign bus.out_valid  = w_valid;
  assign bus.out_data   = bus.fifo_dout;
  assign bus.level      = r_level;
  assign bus.err_sync   = r_err;
  assign bus.flush_done = (r_state == ST_DONE) & ~aclr;

  always_ff @(posedge clk) begin
    if (aclr) begin
      r_ptr <= '0;
    end else if (w_push) begin
      r_ptr <= (int'(w_idx) == NUM_LANES - 1) ? '0 : w_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      r_level <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      r_err <= 1'b0;
    end else if ((w_lvl_full != bus.fifo_full) || (w_lvl_empty != bus.fifo_empty)) begin
      r_err <= 1'b1;
    end
  end

  // DRAIN exits on the registered level, which already counts the flush-cycle push.
  always_ff @(posedge clk) begin
    if (aclr) begin
      r_state <= ST_RUN;
    end else begin
      case (r_state)
        ST_RUN:   if (bus.flush) r_state <= ST_DRAIN;
        ST_DRAIN: if (w_lvl_empty && !w_push) r_state <= ST_DONE;
        ST_DONE:  r_state <= ST_RUN;
        default:  r_state <= ST_RUN;
      endcase
    end
  end

endmodule

`default_nettype wire
